// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC width, trap vector, fetch FSM state encoding.
package cpu_pkg;

  localparam int unsigned     DEF_PC_W         = 12;
  localparam int unsigned     DEF_FLUSH_CYCLES = 2;
  localparam logic [11:0]     DEF_TRAP_VECTOR  = 12'hFF0;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_HALT  = 3'd3
  } state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// PC sequencing control: chooses advance / hold / redirect each cycle and
// drives imem request, IF/ID flush and trap EPC capture.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W         = DEF_PC_W,
  parameter int unsigned     FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter logic [PC_W-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_branch_taken,
  input  logic [PC_W-1:0] i_branch_target,
  input  logic            i_trap,
  input  logic            i_halt,
  input  logic            i_resume,
  input  logic            i_hazard_stall,
  input  logic            i_imem_ready,
  input  logic [PC_W-1:0] i_pc_cur,
  output logic            o_pc_advance,
  output logic            o_pc_redirect,
  output logic [PC_W-1:0] o_pc_target,
  output logic            o_flush,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_epc,
  output logic [2:0]      o_state
);

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            take_trap, take_branch;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    epc_d         = epc_q;
    take_trap     = 1'b0;
    take_branch   = 1'b0;
    o_pc_advance  = 1'b0;
    o_pc_redirect = 1'b0;
    o_pc_target   = '0;
    o_flush       = 1'b0;
    o_imem_req    = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN: begin
        if (i_trap)                                take_trap   = 1'b1;
        else if (i_branch_taken)                   take_branch = 1'b1;
        else if (i_halt) begin
          o_flush = 1'b1;
          state_d = ST_HALT;
        end
        // Keep requesting while imem is busy; a pure hazard stall drops the request.
        else if (i_hazard_stall || !i_imem_ready)  o_imem_req  = !i_imem_ready;
        else begin
          o_pc_advance = 1'b1;
          o_imem_req   = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (i_trap) take_trap = 1'b1;
        else begin
          o_flush      = 1'b1;
          o_imem_req   = 1'b1;
          o_pc_advance = i_imem_ready;
          cnt_d        = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
          if (cnt_q <= 3'd1) state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (i_trap)        take_trap = 1'b1;
        else if (i_resume) state_d   = ST_RUN;
      end
      default: state_d = ST_RESET;
    endcase

    // The accept cycle itself is the first flush cycle, hence FLUSH_CYCLES-1 left.
    if (take_trap || take_branch) begin
      o_pc_redirect = 1'b1;
      o_pc_target   = take_trap ? TRAP_VECTOR : i_branch_target;
      o_flush       = 1'b1;
      o_imem_req    = 1'b1;
      cnt_d         = CNT_INIT;
      state_d       = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
      if (take_trap) epc_d = i_pc_cur;
    end
  end

  assign o_epc   = epc_q;
  assign o_state = state_q;

endmodule
